green_pixel_tagger: RTL
=======================

Name: green_pixel_tagger

Overview:
- Front-end stage of the green-object tracking path, between the camera byte bus and green_mass_center.
- Assembles RGB565 pixels from the camera's two-bytes-per-pixel stream (vsync/href framing) and generates the x_pos/y_pos coordinates.
- Classifies each pixel as green and drives eh_verde.
- Output timing and frame framing are defined so the centroid accumulator downstream counts each visible pixel exactly once.

Parameters:
- H_ACTIVE, 640, pixels per line accepted; later pixels in the same line are dropped.
- V_ACTIVE, 480, lines per frame accepted; later lines are dropped.
- G_MIN, 12, minimum 5-bit green level for a green pixel.
- MARGIN, 4, amount by which green must exceed both red and blue, 5-bit scale.

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  classification enable (board switch); when 0, eh_verde is forced to 0.
- vsync  in  1  camera vertical sync, active high during frame blanking.
- href  in  1  camera line-valid, high during active bytes of a line.
- data  in  8  camera byte bus.
- rgb565  out  16  last assembled pixel.
- pixel_valid  out  1  one-cycle strobe: rgb565/x_pos/y_pos/eh_verde describe a new pixel.
- x_pos  out  10  column of presented pixel.
- y_pos  out  10  row of presented pixel.
- eh_verde  out  1  pixel is green; only ever high together with pixel_valid.
- frame_start  out  1  one-cycle pulse on vsync falling edge.
- frame_done  out  1  one-cycle pulse on vsync rising edge.
- overflow  out  1  sticky flag: a line exceeded H_ACTIVE pixels or a frame exceeded V_ACTIVE lines; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, byte phase 0, column counter 0, row counter 0, first-byte register 0, vsync/href history 0.
- Inputs are sampled on every rising edge. vsync and href are each registered once to detect edges.

Byte assembly (while href=1):
- Phase 0: store data as the high byte (RRRRRGGG), then go to phase 1.
- Phase 1: pixel = {stored high byte, data}, then go to phase 0.
- When href=0, phase returns to 0. A partial pixel at the end of a line is discarded.

Pixel output:
- On the edge that samples a phase-1 byte, if col < H_ACTIVE and row < V_ACTIVE, register rgb565, x_pos=col, y_pos=row, pixel_valid=1 and eh_verde. col then increments.
- Latency: outputs are valid in the cycle after the second byte is sampled.
- pixel_valid and eh_verde drop to 0 on the next edge unless another pixel completes.
- x_pos and y_pos hold their last value between pixels.

Drops and overflow:
- A pixel completing with col ≥ H_ACTIVE: no pixel_valid, col saturates at H_ACTIVE, overflow is set.
- With row ≥ V_ACTIVE: no pixel_valid, overflow is set.

Line and frame counting:
- href falling edge: col ← 0; row ← row+1, saturating at V_ACTIVE.
- vsync rising edge: frame_done=1 for one cycle; col ← 0, row ← 0, phase ← 0; x_pos and y_pos are driven to 0.
- vsync falling edge: frame_start=1 for one cycle.
- While vsync=1, href is ignored and no pixels are produced.
- x_pos=y_pos=0 during vertical blanking provides the frame boundary that the downstream centroid block keys on.

Classification (combinational from the assembled pixel, registered with pixel_valid):
- r = R5, g = G6>>1, b = B5.
- green = enable AND g ≥ G_MIN AND g ≥ r+MARGIN AND g ≥ b+MARGIN.
- Sums are computed at 6 bits, so there is no wrap.

Simultaneous events and mid-operation reset:
- href falling on the same edge as a phase-1 byte: the pixel completes first with the old col/row, then the line-end update applies.
- vsync rising while href=1: frame handling wins; any partial pixel is discarded.
- Asynchronous reset mid-line: all state clears immediately. The rest of that frame produces pixels starting at col 0 of the current row count 0 until the next vsync realigns.

Test Plan:
1. Reset asserted mid-line, then released, with vsync pulse and one href line of 2 pixels {0x07,0xE0}, {0xF8,0x00} -> pixel_valid pulses at x_pos 0 and 1, y_pos 0; rgb565 0x07E0 with eh_verde=1, then 0xF800 with eh_verde=0.
2. Threshold edge cases, enable=1 -> g=12, r=8, b=8: eh_verde=1; g=12, r=9: eh_verde=0; g=11, r=b=0: eh_verde=0. With enable=0 and a pure green pixel -> pixel_valid=1, eh_verde=0.
3. Three lines of 4 pixels each, then vsync -> last pixel at x=3, y=2; frame_done pulses; x_pos=y_pos=0 after the vsync edge; frame_start pulses on vsync fall.
4. Line with an odd byte count of 5 -> exactly 2 pixel_valid strobes; the dangling byte is discarded; the next line starts at x=0, y=1.
5. H_ACTIVE=4 with a 6-pixel line -> 4 strobes at x=0..3; overflow=1 and remains 1 through the next frame until reset.
6. href falling on the edge of a second byte -> that pixel is reported with the current row; the next line's first pixel has y_pos incremented by exactly 1.

Source files
------------

// File: rtl/green_pixel_tagger.sv
// Camera front end: assembles RGB565 pixels from the vsync/href byte stream,
// tracks pixel coordinates and tags green pixels for the centroid stage.
module green_pixel_tagger #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int G_MIN    = 12,
    parameter int MARGIN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  data,
    output logic [15:0] rgb565,
    output logic        pixel_valid,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        eh_verde,
    output logic        frame_start,
    output logic        frame_done,
    output logic        overflow
);

    localparam logic [9:0] H_MAX  = 10'(H_ACTIVE);
    localparam logic [9:0] V_MAX  = 10'(V_ACTIVE);
    localparam logic [5:0] G_MIN6 = 6'(G_MIN);
    localparam logic [5:0] MARG6  = 6'(MARGIN);

    logic       phase;
    logic [7:0] hi_byte;
    logic [9:0] col;
    logic [9:0] row;
    logic       vsync_q;
    logic       href_q;

    logic        href_eff;
    logic        vsync_rise;
    logic        vsync_fall;
    logic        href_fall;
    logic [15:0] pixel;
    logic [5:0]  r6;
    logic [5:0]  g6;
    logic [5:0]  b6;
    logic        is_green;

    // href has no meaning during vertical blanking, so mask it before edge detection.
    assign href_eff   = href & ~vsync;
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign href_fall  = href_q & ~href_eff;

    assign pixel    = {hi_byte, data};
    assign r6       = {1'b0, pixel[15:11]};
    assign g6       = {1'b0, pixel[10:6]};
    assign b6       = {1'b0, pixel[4:0]};
    assign is_green = enable && (g6 >= G_MIN6) && (g6 >= r6 + MARG6) && (g6 >= b6 + MARG6);

    // Output stream is valid-only (no ready): pixel_valid is a one-cycle strobe and
    // rgb565/x_pos/y_pos/eh_verde are meaningful in exactly that cycle; the
    // consumer must take every strobe since nothing can stall the camera.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            col         <= 10'd0;
            row         <= 10'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            rgb565      <= 16'd0;
            pixel_valid <= 1'b0;
            x_pos       <= 10'd0;
            y_pos       <= 10'd0;
            eh_verde    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            href_q      <= href_eff;
            frame_done  <= vsync_rise;
            frame_start <= vsync_fall;
            pixel_valid <= 1'b0;
            eh_verde    <= 1'b0;
            if (vsync_rise) begin
                col   <= 10'd0;
                row   <= 10'd0;
                phase <= 1'b0;
                x_pos <= 10'd0;
                y_pos <= 10'd0;
            end else if (href_eff) begin
                if (!phase) begin
                    hi_byte <= data;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (col < H_MAX && row < V_MAX) begin
                        rgb565      <= pixel;
                        x_pos       <= col;
                        y_pos       <= row;
                        pixel_valid <= 1'b1;
                        eh_verde    <= is_green;
                        col         <= col + 10'd1;
                    end else begin
                        // col can only reach H_MAX, so it stays saturated here.
                        overflow <= 1'b1;
                    end
                end
            end else begin
                phase <= 1'b0;
                if (href_fall) begin
                    col <= 10'd0;
                    if (row < V_MAX) begin
                        row <= row + 10'd1;
                    end
                end
            end
        end
    end

endmodule
